// File: rtl/dcache_mem_ctrl_if.sv
// Cache/RAM bus bundle: dcache and icache request ports on one side, RAM strobes on the other.
// The slave modport is the memory controller; master is the cache/RAM environment.
interface dcache_mem_ctrl_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          dREN;
   logic          dWEN;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dstore;
   logic [DW-1:0] dload;
   logic          dwait;
   logic          iREN;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] iload;
   logic          iwait;
   logic          ramREN;
   logic          ramWEN;
   logic [AW-1:0] ramaddr;
   logic [DW-1:0] ramstore;
   logic [DW-1:0] ramload;

   modport slave (
      input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload,
      output dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload,
      input  dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// Memory-side responder: arbitrates dcache/icache word requests onto a fixed-latency
// single-port RAM and returns one wait-low cycle per completed word.
module dcache_mem_ctrl #(
   parameter int LAT = 2,
   parameter int AW  = 32,
   parameter int DW  = 32
) (
   input logic              CLK,
   input logic              RST,
   dcache_mem_ctrl_if.slave mif
);
   localparam int CW = $clog2(LAT) + 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DACC  = 3'd1;
   localparam logic [2:0] IACC  = 3'd2;
   localparam logic [2:0] DRESP = 3'd3;
   localparam logic [2:0] IRESP = 3'd4;

   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          last_i_reg, last_i_next;
   logic [DW-1:0] dload_reg, dload_next;
   logic [DW-1:0] iload_reg, iload_next;

   logic d_pend, i_pend, cnt_done;

   assign d_pend   = mif.dREN | mif.dWEN;
   assign i_pend   = mif.iREN;
   assign cnt_done = (cnt_reg == CW'(LAT - 1));

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      last_i_next = last_i_reg;
      dload_next  = dload_reg;
      iload_next  = iload_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            // On a tie the icache wins only if the dcache was served last.
            if (d_pend && (!i_pend || last_i_reg)) begin
               state_next  = DACC;
               last_i_next = 1'b0;
            end else if (i_pend) begin
               state_next  = IACC;
               last_i_next = 1'b1;
            end
         end
         DACC: begin
            cnt_next = cnt_reg + CW'(1);
            if (!d_pend) begin
               state_next = IDLE;
            end else if (cnt_done) begin
               if (!mif.dWEN) dload_next = mif.ramload;
               state_next = DRESP;
            end
         end
         IACC: begin
            cnt_next = cnt_reg + CW'(1);
            if (!i_pend) begin
               state_next = IDLE;
            end else if (cnt_done) begin
               iload_next = mif.ramload;
               state_next = IRESP;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         last_i_reg <= 1'b1;
         dload_reg  <= '0;
         iload_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         last_i_reg <= last_i_next;
         dload_reg  <= dload_next;
         iload_reg  <= iload_next;
      end
   end

   // Strobes are gated by the live request so an abort drops them in the same cycle.
   always_comb begin
      mif.ramREN   = 1'b0;
      mif.ramWEN   = 1'b0;
      mif.ramaddr  = {AW{1'b0}};
      mif.ramstore = {DW{1'b0}};
      if (state_reg == DACC && d_pend) begin
         mif.ramaddr = mif.daddr;
         if (mif.dWEN) begin
            mif.ramWEN   = 1'b1;
            mif.ramstore = mif.dstore;
         end else begin
            mif.ramREN = 1'b1;
         end
      end else if (state_reg == IACC && i_pend) begin
         mif.ramREN  = 1'b1;
         mif.ramaddr = mif.iaddr;
      end
   end

   assign mif.dwait = (state_reg != DRESP);
   assign mif.iwait = (state_reg != IRESP);
   assign mif.dload = dload_reg;
   assign mif.iload = iload_reg;
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed bench for dcache_mem_ctrl with LAT=2 and a RAM model whose read data is valid
// only in the last strobe cycle.
module tb_dcache_mem_ctrl;
   localparam int LAT = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic CLK;
   logic RST;
   logic [31:0] rdata;
   int strobe_cnt;
   int n_assert;
   int n_fail;

   dcache_mem_ctrl_if #(.AW(AW), .DW(DW)) mif ();

   dcache_mem_ctrl #(.LAT(LAT), .AW(AW), .DW(DW)) dut (
      .CLK (CLK),
      .RST (RST),
      .mif (mif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RST) strobe_cnt <= 0;
      else if (mif.ramREN || mif.ramWEN) strobe_cnt <= strobe_cnt + 1;
      else strobe_cnt <= 0;
   end

   always_comb begin
      mif.ramload = 32'hBAD0_BAD0;
      if ((mif.ramREN || mif.ramWEN) && strobe_cnt == LAT - 1) mif.ramload = rdata;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_dacc(input logic wen, input logic [31:0] addr, input logic [31:0] store,
                          input logic [31:0] rd, input logic [31:0] exp_ld);
      logic strobe;
      mif.dREN = 1'b1; mif.dWEN = wen; mif.daddr = addr; mif.dstore = store; rdata = rd;
      for (int c = 0; c <= LAT + 2; c++) begin
         @(negedge CLK);
         strobe = (c >= 1) && (c <= LAT);
         check("dacc_ramREN", mif.ramREN, strobe && !wen);
         check("dacc_ramWEN", mif.ramWEN, strobe && wen);
         check("dacc_ramaddr", mif.ramaddr, strobe ? addr : 32'h0);
         check("dacc_ramstore", mif.ramstore, (strobe && wen) ? store : 32'h0);
         check("dacc_dwait", mif.dwait, c != LAT + 1);
         check("dacc_iwait", mif.iwait, 1'b1);
         if (c == LAT + 1) begin
            check("dacc_dload", mif.dload, exp_ld);
            mif.dREN = 1'b0; mif.dWEN = 1'b0;
         end
         next_cycle();
      end
      $display("txn dcache %s addr=%08h dload=%08h", wen ? "write" : "read", addr, mif.dload);
   endtask

   initial begin
      n_assert = 0; n_fail = 0;
      RST = 1'b1; rdata = 32'h0;
      mif.dREN = 1'b0; mif.dWEN = 1'b0; mif.daddr = '0; mif.dstore = '0;
      mif.iREN = 1'b0; mif.iaddr = '0;
      next_cycle(); next_cycle();
      RST = 1'b0;

      // Reset then idle
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check("idle_dwait", mif.dwait, 1'b1);
         check("idle_iwait", mif.iwait, 1'b1);
         check("idle_ramREN", mif.ramREN, 1'b0);
         check("idle_ramWEN", mif.ramWEN, 1'b0);
         check("idle_dload", mif.dload, 32'h0);
         check("idle_iload", mif.iload, 32'h0);
         next_cycle();
      end
      $display("txn reset-idle checked");

      do_dacc(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_dacc(1'b1, 32'h80, 32'h1234_5678, 32'h5555_5555, 32'hDEAD_BEEF);

      // Both caches requesting from reset: D first, then alternate
      RST = 1'b1;
      mif.dREN = 1'b1; mif.daddr = 32'h100; mif.iREN = 1'b1; mif.iaddr = 32'h200;
      rdata = 32'hCAFE_F00D;
      next_cycle();
      RST = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge CLK);
         check("alt_dwait", mif.dwait, !((c % 4 == 3) && ((c / 4) % 2 == 0)));
         check("alt_iwait", mif.iwait, !((c % 4 == 3) && ((c / 4) % 2 == 1)));
         check("alt_ramREN", mif.ramREN, (c % 4 == 1) || (c % 4 == 2));
         check("alt_ramaddr", mif.ramaddr,
               ((c % 4 == 1) || (c % 4 == 2)) ? (((c / 4) % 2 == 0) ? 32'h100 : 32'h200) : 32'h0);
         if (c == 3)  check("alt_dload", mif.dload, 32'hCAFE_F00D);
         if (c == 7)  check("alt_iload", mif.iload, 32'hCAFE_F00D);
         if (c % 4 == 3) $display("txn alternating grant %0s done at cycle %0d", ((c / 4) % 2 == 0) ? "D" : "I", c);
         if (c == 15) begin mif.dREN = 1'b0; mif.iREN = 1'b0; end
         next_cycle();
      end

      // Icache abort in second access cycle, then a fresh icache read
      mif.iREN = 1'b1; mif.iaddr = 32'h300; rdata = 32'h1111_2222;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) mif.iREN = 1'b0;
         if (c == 3) begin mif.iREN = 1'b1; mif.iaddr = 32'h304; end
         @(negedge CLK);
         check("abort_ramREN", mif.ramREN, (c == 1) || (c == 4) || (c == 5));
         check("abort_ramaddr", mif.ramaddr,
               (c == 1) ? 32'h300 : ((c == 4) || (c == 5)) ? 32'h304 : 32'h0);
         check("abort_iwait", mif.iwait, c != 6);
         if (c >= 2 && c <= 5) check("abort_iload_hold", mif.iload, 32'hCAFE_F00D);
         if (c == 6) begin
            check("abort_iload_new", mif.iload, 32'h1111_2222);
            mif.iREN = 1'b0;
         end
         next_cycle();
      end
      $display("txn icache abort then read iload=%08h", mif.iload);

      // Reset during DACC, request held and completes afterwards
      mif.dREN = 1'b1; mif.daddr = 32'h44; rdata = 32'h2468_ACE0;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) RST = 1'b1;
         if (c == 2) RST = 1'b0;
         @(negedge CLK);
         check("rst_ramREN", mif.ramREN, (c == 1) || (c == 3) || (c == 4));
         check("rst_dwait", mif.dwait, c != 5);
         if (c == 2) begin
            check("rst_dload_clr", mif.dload, 32'h0);
            check("rst_iload_clr", mif.iload, 32'h0);
         end
         if (c == 5) begin
            check("rst_dload_new", mif.dload, 32'h2468_ACE0);
            mif.dREN = 1'b0;
         end
         next_cycle();
      end
      $display("txn reset mid-access then dcache read dload=%08h", mif.dload);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
